// File: rtl/data_sink.sv
// Receive-side message sink: buffers one GF(16) information frame, checks it against
// the fixed test message and reports completion. Define GOLDEN_CHECK_EN to compile in the checker.
module data_sink #(
    parameter int unsigned MSG_LEN     = 11,
    parameter int unsigned SYM_W       = 4,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sof,
    input  logic                   data_valid,
    input  logic [0:SYM_W-1]       Data_in,
    input  logic [3:0]             rd_addr,
    output logic [0:SYM_W-1]       rd_data,
    output logic                   busy,
    output logic                   end_of_frame,
    output logic                   frame_ok,
    output logic [3:0]             err_count,
    output logic [FRAME_CNT_W-1:0] frames_rx,
    output logic                   frame_abort
);

    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] BUF_LEN  = IDX_W'(MSG_LEN);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RECEIVE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]             state, state_next;
    logic [IDX_W-1:0]       index, index_next;
    logic [0:SYM_W-1]       buffer [MSG_LEN];
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic                   mismatch;
    logic [3:0]             err_inc;
    logic                   busy_next, eof_next, ok_next, abort_next;
    logic [3:0]             err_next;
    logic [FRAME_CNT_W-1:0] frames_next;

`ifdef GOLDEN_CHECK_EN
    // Test message X^0, X^1, X^4, X^2, X^8, X^5, X^10, X^3, X^14, X^9, X^7; zero beyond.
    function automatic logic [0:SYM_W-1] golden(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return 4'b1000;
            4'd1:    return 4'b0100;
            4'd2:    return 4'b1100;
            4'd3:    return 4'b0010;
            4'd4:    return 4'b1010;
            4'd5:    return 4'b0110;
            4'd6:    return 4'b1110;
            4'd7:    return 4'b0001;
            4'd8:    return 4'b1001;
            4'd9:    return 4'b0101;
            4'd10:   return 4'b1101;
            default: return 4'b0000;
        endcase
    endfunction
`endif

    // A sof symbol always lands in word 0; otherwise continue at the running index.
    always_comb begin
        wr_idx = (state == S_RECEIVE && !sof) ? index : '0;
`ifdef GOLDEN_CHECK_EN
        mismatch = (Data_in != golden(wr_idx));
`else
        mismatch = 1'b0;
`endif
        err_inc = (err_count == 4'hF) ? err_count : err_count + 4'(mismatch);
    end

    always_comb begin
        state_next  = state;
        index_next  = index;
        wr_en       = 1'b0;
        busy_next   = busy;
        eof_next    = 1'b0;
        abort_next  = 1'b0;
        ok_next     = frame_ok;
        err_next    = err_count;
        frames_next = frames_rx;
        case (state)
            S_IDLE: begin
                if (data_valid && sof) begin
                    wr_en      = 1'b1;
                    index_next = IDX_W'(1);
                    err_next   = 4'(mismatch);
                    ok_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (data_valid) begin
                    wr_en = 1'b1;
                    if (sof) begin
                        abort_next = 1'b1;
                        index_next = IDX_W'(1);
                        err_next   = 4'(mismatch);
                        ok_next    = 1'b0;
                    end else if (index == LAST_IDX) begin
                        err_next    = err_inc;
                        ok_next     = (err_inc == 4'd0);
                        eof_next    = 1'b1;
                        busy_next   = 1'b0;
                        index_next  = '0;
                        frames_next = (&frames_rx) ? frames_rx : frames_rx + FRAME_CNT_W'(1);
                        state_next  = S_DONE;
                    end else begin
                        err_next   = err_inc;
                        index_next = index + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            index        <= '0;
            busy         <= 1'b0;
            end_of_frame <= 1'b0;
            frame_abort  <= 1'b0;
            frame_ok     <= 1'b0;
            err_count    <= '0;
            frames_rx    <= '0;
            buffer       <= '{default: '0};
        end else begin
            state        <= state_next;
            index        <= index_next;
            busy         <= busy_next;
            end_of_frame <= eof_next;
            frame_abort  <= abort_next;
            frame_ok     <= ok_next;
            err_count    <= err_next;
            frames_rx    <= frames_next;
            if (wr_en) begin
                buffer[wr_idx] <= Data_in;
            end
        end
    end

    // Random-access read; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (rd_addr < BUF_LEN) begin
            rd_data = buffer[rd_addr];
        end
    end

endmodule

// File: tb/tb_data_sink.sv
// Scoreboarded random bench for data_sink; reference model follows GOLDEN_CHECK_EN like the DUT.
module tb_data_sink;

    localparam int MSG_LEN = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof = 1'b0;
    logic       data_valid = 1'b0;
    logic [0:3] Data_in = 4'b0000;
    logic [3:0] rd_addr = 4'd0;
    logic [0:3] rd_data;
    logic       busy, end_of_frame, frame_ok, frame_abort;
    logic [3:0] err_count;
    logic [7:0] frames_rx;

    data_sink #(.MSG_LEN(MSG_LEN)) dut (
        .clk(clk), .reset(reset), .sof(sof), .data_valid(data_valid),
        .Data_in(Data_in), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .end_of_frame(end_of_frame), .frame_ok(frame_ok),
        .err_count(err_count), .frames_rx(frames_rx), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       ok;
        int         err;
        int         frames;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [0:3] gold [11] = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b1010, 4'b0110,
                              4'b1110, 4'b0001, 4'b1001, 4'b0101, 4'b1101};

    // Reference model state
    bit         in_frame;
    bit         done_gap;
    logic [0:3] syms[$];
    logic [0:3] mbuf [16];
    int         frames_exp;
    logic       last_ok;
    int         last_err;
    int         abort_exp = 0;
    int         abort_seen = 0;
    logic [0:3] fr [MSG_LEN];
    int         stall_at = -1;
    int         stall_len = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic int frame_errs();
        int n = 0;
`ifdef GOLDEN_CHECK_EN
        for (int i = 0; i < syms.size(); i++) begin
            logic [0:3] g;
            g = (i < 11) ? gold[i] : 4'b0000;
            if (syms[i] != g) n++;
        end
        if (n > 15) n = 15;
`endif
        return n;
    endfunction

    task automatic model_reset();
        in_frame   = 0;
        done_gap   = 0;
        syms.delete();
        for (int i = 0; i < 16; i++) mbuf[i] = 4'b0000;
        frames_exp = 0;
        last_ok    = 1'b0;
        last_err   = 0;
        exp_q.delete();
    endtask

    task automatic model_apply(input bit s, input bit v, input logic [0:3] d);
        exp_t e;
        if (done_gap) begin
            done_gap = 0;
            return;
        end
        if (!v) return;
        if (!in_frame) begin
            if (!s) return;
            in_frame = 1;
            syms.delete();
            last_ok = 1'b0;
        end else if (s) begin
            abort_exp++;
            syms.delete();
        end
        syms.push_back(d);
        if (syms.size() == MSG_LEN) begin
            for (int i = 0; i < MSG_LEN; i++) mbuf[i] = syms[i];
            if (frames_exp < 255) frames_exp++;
            e.cyc    = cyc + 1;
            e.err    = frame_errs();
            e.ok     = (e.err == 0);
            e.frames = frames_exp;
            last_ok  = e.ok;
            last_err = e.err;
            exp_q.push_back(e);
            in_frame = 0;
            done_gap = 1;
        end
    endtask

    task automatic step(input bit s, input bit v, input logic [0:3] d);
        chk("busy", int'(busy), int'(in_frame));
        sof = s;
        data_valid = v;
        Data_in = d;
        model_apply(s, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000);
    endtask

    task automatic do_reset(input int n, input bit v, input logic [0:3] d);
        reset = 1'b1;
        sof = 1'b0;
        data_valid = v;
        Data_in = d;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input bit rnd);
        for (int i = 0; i < MSG_LEN; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            step(i == 0, 1'b1, fr[i]);
            if (i == stall_at) idle(stall_len);
        end
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_frame_ok"}, int'(frame_ok), int'(last_ok));
        chk({tag, "_err_count"}, int'(err_count), last_err);
        chk({tag, "_frames_rx"}, int'(frames_rx), frames_exp);
        chk({tag, "_aborts"}, abort_seen, abort_exp);
    endtask

    task automatic check_buffer(input string tag);
        data_valid = 1'b0;
        sof = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk({tag, "_rd_data"}, int'(rd_data), (a < MSG_LEN) ? int'(mbuf[a]) : 0);
        end
        rd_addr = 4'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_gold();
        for (int i = 0; i < MSG_LEN; i++) fr[i] = gold[i];
    endtask

    // Monitor: pops the scoreboard on each end_of_frame and counts abort pulses.
    always @(negedge clk) begin
        exp_t e;
        if (frame_abort) abort_seen++;
        if (end_of_frame) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL eof_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("eof_cycle", cyc, e.cyc);
                chk("eof_frame_ok", int'(frame_ok), int'(e.ok));
                chk("eof_err_count", int'(err_count), e.err);
                chk("eof_frames_rx", int'(frames_rx), e.frames);
                chk("eof_busy", int'(busy), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2, 1'b0, 4'b0000);
        chk("rst_eof", int'(end_of_frame), 0);
        chk("rst_abort", int'(frame_abort), 0);
        check_held("rst");
        check_buffer("rst");

        // Nominal golden frame plus the source's trailing zero symbol
        load_gold();
        send_frame(1'b0);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0000);
        idle(1);
        check_held("nominal");
        check_buffer("nominal");

        // Corrupted symbols at 2 and 9
        load_gold();
        fr[2] = 4'b0000;
        fr[9] = 4'b1111;
        send_frame(1'b0);
        idle(2);
        check_held("corrupt");
        check_buffer("corrupt");

        // Three stall cycles between symbols 4 and 5
        load_gold();
        stall_at = 4;
        stall_len = 3;
        send_frame(1'b0);
        stall_at = -1;
        idle(2);
        check_held("stall");

        // A sof arriving in the DONE cycle is dropped along with its followers
        load_gold();
        send_frame(1'b0);
        step(1'b1, 1'b1, 4'b1111);
        for (int i = 1; i < MSG_LEN; i++) step(1'b0, 1'b1, 4'b1111);
        idle(2);
        check_held("done_ignore");
        check_buffer("done_ignore");

        // Restart after six symbols
        load_gold();
        for (int i = 0; i < 6; i++) step(i == 0, 1'b1, 4'(i * 3));
        send_frame(1'b0);
        idle(2);
        check_held("restart");
        check_buffer("restart");

        // Reset landing on symbol 5 discards the partial frame
        load_gold();
        for (int i = 0; i < 5; i++) step(i == 0, 1'b1, fr[i]);
        do_reset(1, 1'b1, fr[5]);
        idle(1);
        check_held("midreset");
        check_buffer("midreset");
        send_frame(1'b0);
        idle(2);
        check_held("after_reset");
        check_buffer("after_reset");

        // Randomized frames, occasional corruption, aborts and stalls
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < MSG_LEN; i++)
                fr[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : gold[i];
            if ($urandom_range(0, 4) == 0) begin
                int part = $urandom_range(1, MSG_LEN - 1);
                for (int i = 0; i < part; i++) step(i == 0, 1'b1, 4'($urandom));
            end
            send_frame(1'b1);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 4'b0000);
            idle($urandom_range(1, 2));
            check_held("random");
        end
        check_buffer("random");

        // Drive frames_rx into saturation
        load_gold();
        for (int k = 0; k < 250; k++) begin
            send_frame(1'b0);
            idle(1);
        end
        idle(1);
        check_held("saturate");

        chk("pending_eof", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_sink.md
Name: data_sink

Overview:
- Receive-side counterpart of the message source: accepts a stream of GF(16) symbols on a 4-bit bus from the decoder output and assembles one fixed-length information message in a local buffer.
- Checks each symbol against the fixed test message, then reports frame completion, error count and pass/fail.
- Buffered message is readable through a random-access read port until the next frame starts.

Parameters:
- MSG_LEN, 11, information symbols per frame (legal range 2..15).
- SYM_W, 4, symbol width; GF(16), fixed at 4.
- FRAME_CNT_W, 8, width of received-frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sof  in  1  start of frame; qualified by data_valid, marks the first symbol.
- data_valid  in  1  Data_in carries a valid symbol this cycle.
- Data_in  in  [0:3]  symbol; bit 0 = X^0 coefficient, bit 3 = X^3.
- rd_addr  in  4  buffer read address, 0..MSG_LEN-1.
- rd_data  out  [0:3]  buffer word at rd_addr, combinational read; 4'b0000 if rd_addr >= MSG_LEN.
- busy  out  1  frame reception in progress.
- end_of_frame  out  1  one-cycle pulse when a complete frame has been received.
- frame_ok  out  1  valid with end_of_frame and held until next accepted sof; 1 = zero mismatches.
- err_count  out  4  mismatching symbols in last frame; held like frame_ok.
- frames_rx  out  FRAME_CNT_W  completed frames, saturating at all-ones.
- frame_abort  out  1  one-cycle pulse when a frame is restarted by sof mid-frame.

Behaviour:
- Reset values:
  - Outputs: busy=0, end_of_frame=0, frame_ok=0, err_count=0, frames_rx=0, frame_abort=0.
  - Buffer: all words 4'b0000.
  - Internals: symbol index=0, state=IDLE.
  - Reset mid-frame discards the partial frame without an end_of_frame or frame_abort pulse.
- States: IDLE, RECEIVE, DONE.
- IDLE:
  - Symbols with data_valid=1 and sof=0 are ignored. This covers the trailing 4'b0000 the source emits after its message.
  - sof=1 and data_valid=1 accepts the frame:
    - Data_in is written to buffer[0], index=1.
    - err_count/frame_ok are cleared; the buffer is not pre-cleared.
    - busy=1; go to RECEIVE.
- RECEIVE:
  - Each data_valid=1 cycle writes Data_in to buffer[index] and increments index.
  - data_valid=0 cycles are stalls; state and buffer are unchanged. There is no timeout.
  - Mismatch check on every accepted symbol, including symbol 0: symbol != golden[index] increments err_count, saturating at 15.
  - When the symbol at index MSG_LEN-1 is written, go to DONE.
- sof=1 with data_valid=1 in RECEIVE:
  - frame_abort pulses for one cycle and the frame restarts.
  - This symbol becomes buffer[0], index=1, err_count is re-evaluated from this symbol, and the state stays RECEIVE.
- DONE (exactly one cycle):
  - end_of_frame=1, frame_ok=(err_count==0), frames_rx increments (saturating), busy=0, go to IDLE.
  - end_of_frame therefore rises one cycle after the clock edge that accepts the last symbol.
  - An input symbol presented during DONE is ignored, even with sof=1. Back-to-back frames need one gap cycle.
- Golden message, bit strings in [0:3] order, indices 0..10:
  - 1000, 0100, 1100, 0010, 1010, 0110, 1110, 0001, 1001, 0101, 1101
  - (X^0, X^1, X^4, X^2, X^8, X^5, X^10, X^3, X^14, X^9, X^7).
  - Golden entries for indices >= 11 are 0000.
- Read port: the buffer is readable at any time. Contents are stable from end_of_frame until the next accepted sof.

Optional Feature:
- GOLDEN_CHECK_EN
  - Defined: golden table and comparison are compiled in, behaving as described above.
  - Undefined: no comparator or table; err_count is tied to 0 and frame_ok=1 at every end_of_frame; all other behaviour is identical.

Test Plan:
- Nominal frame: reset, then sof+data_valid with the 11 golden symbols on consecutive cycles, then 0000 -> end_of_frame one cycle after symbol 10, frame_ok=1, err_count=0, frames_rx=1; rd_addr 0..10 returns the golden list; the trailing 0000 is ignored.
- Corrupted symbols: golden frame with index 2 = 0000 and index 9 = 1111 -> frame_ok=0, err_count=2, rd_data at addr 9 = 1111 (with GOLDEN_CHECK_EN).
- Stalls: golden frame with data_valid low for 3 cycles between symbols 4 and 5 -> end_of_frame asserts 3 cycles later than nominal, frame_ok=1.
- Restart: sof after 6 symbols, then a full golden frame -> frame_abort pulses once, then end_of_frame with frame_ok=1, frames_rx=1.
- Mid-frame reset: reset asserted at symbol 5 for one cycle -> all outputs return to reset values, no end_of_frame; the next golden frame completes normally.
- Feature off (GOLDEN_CHECK_EN undefined): frame of all 1111 -> end_of_frame with frame_ok=1, err_count=0.
